// File: rtl/pinmux_pkg.sv
// pinmux_pkg: shared constants and helpers for the IO pad multiplexer.
//   - Register byte offsets relative to the block base address
//   - Pads-per-SEL-word and per-word writable-bit mask helpers
//   - Legal ranges for NUM_FUNCS and SYNC_STAGES, with predicate functions
package pinmux_pkg;

    localparam logic [31:0] SEL_OFS  = 32'h0000_0000;
    localparam logic [31:0] LOCK_OFS = 32'h0000_0100;
    localparam logic [31:0] IN_OFS   = 32'h0000_0200;

    localparam int unsigned MIN_FUNCS  = 2;
    localparam int unsigned MAX_FUNCS  = 16;
    localparam int unsigned MIN_STAGES = 2;
    localparam int unsigned MAX_STAGES = 4;

    // Number of pad select fields packed into one 32-bit SEL word.
    function automatic int unsigned pads_per_word(input int unsigned selw);
        return 32 / selw;
    endfunction

    // Bits of SEL word 'word' that belong to an existing pad. Trailing bits
    // (when selw does not divide 32) and bits of pads >= num_pads are 0.
    function automatic logic [31:0] sel_word_mask(input int unsigned word,
                                                  input int unsigned num_pads,
                                                  input int unsigned selw);
        logic [31:0]  m;
        int unsigned  ppw;
        m   = '0;
        ppw = pads_per_word(selw);
        for (int unsigned b = 0; b < 32; b++) begin
            if ((b < ppw * selw) && (word * ppw + b / selw < num_pads)) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic bit funcs_legal(input int unsigned n);
        return (n >= MIN_FUNCS) && (n <= MAX_FUNCS) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit stages_legal(input int unsigned n);
        return (n >= MIN_STAGES) && (n <= MAX_STAGES);
    endfunction

endpackage

// File: rtl/pinmux_sync.sv
// pinmux_sync: multi-bit flip-flop chain synchroniser.
//   i_clk  clock
//   i_rst  synchronous active-high reset, clears every stage
//   i_d    asynchronous input bits
//   o_q    input bits delayed by STAGES clocks
module pinmux_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/io_pinmux_wb.sv
// io_pinmux_wb: Wishbone-programmable pad multiplexer.
//   wb_clk_i / wb_rst_i     clock, synchronous active-high reset
//   wbs_*                   classic single-beat Wishbone slave
//   io_in / io_out / io_oeb user pad signals (oeb active-low)
//   periph_out / periph_oe  per-pad, per-function peripheral drive, index pad*NUM_FUNCS+func
//   periph_in               synchronised pad input, only on the selected function
//   locked_o                configuration lock status
// Registers: SEL words at +0x000, LOCK at +0x100, IN snapshot words at +0x200.
module io_pinmux_wb
    import pinmux_pkg::*;
#(
    parameter int unsigned NUM_PADS    = 37,
    parameter int unsigned NUM_FUNCS   = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    input  logic [NUM_PADS-1:0]           io_in,
    output logic [NUM_PADS-1:0]           io_out,
    output logic [NUM_PADS-1:0]           io_oeb,
    input  logic [NUM_PADS*NUM_FUNCS-1:0] periph_out,
    input  logic [NUM_PADS*NUM_FUNCS-1:0] periph_oe,
    output logic [NUM_PADS*NUM_FUNCS-1:0] periph_in,
    output logic                          locked_o
);

    localparam int unsigned SELW          = $clog2(NUM_FUNCS);
    localparam int unsigned PPW           = pads_per_word(SELW);
    localparam int unsigned NUM_SEL_WORDS = (NUM_PADS + PPW - 1) / PPW;
    localparam int unsigned NUM_IN_WORDS  = (NUM_PADS + 31) / 32;

    if (!funcs_legal(NUM_FUNCS)) begin : g_bad_funcs
        $error("io_pinmux_wb: NUM_FUNCS must be a power of two in 2..16");
    end
    if (!stages_legal(SYNC_STAGES)) begin : g_bad_stages
        $error("io_pinmux_wb: SYNC_STAGES must be in 2..4");
    end
    if ((NUM_PADS < 1) || (NUM_PADS > 64)) begin : g_bad_pads
        $error("io_pinmux_wb: NUM_PADS must be in 1..64");
    end

    logic [31:0]               r_sel_w [NUM_SEL_WORDS];
    logic                      r_lock;
    logic                      r_ack;
    logic [31:0]               r_dat;

    logic [NUM_PADS-1:0]       w_sync;
    logic [NUM_IN_WORDS*32-1:0] w_sync_ext;
    logic                      w_req;
    logic                      w_wr;
    logic [29:0]               w_widx;
    logic [29:0]               w_in_idx;
    logic                      w_is_sel;
    logic                      w_is_lock;
    logic                      w_is_in;
    logic [31:0]               w_bmask;
    logic [31:0]               w_rdata;
    logic [1:0]                w_unused_adr;

    pinmux_sync #(
        .WIDTH  (NUM_PADS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk (wb_clk_i),
        .i_rst (wb_rst_i),
        .i_d   (io_in),
        .o_q   (w_sync)
    );

    // ---------------------------------------------------------------
    // Wishbone decode. Word index relative to the base; addresses below
    // the base wrap to a huge index and so match nothing.
    // ---------------------------------------------------------------
    assign w_unused_adr = wbs_adr_i[1:0];
    assign w_req     = wbs_stb_i & wbs_cyc_i & ~r_ack;
    assign w_wr      = w_req & wbs_we_i;
    assign w_widx    = wbs_adr_i[31:2] - BASE_ADDR[31:2];
    assign w_in_idx  = w_widx - IN_OFS[31:2];
    assign w_is_sel  = (w_widx >= SEL_OFS[31:2]) && (w_widx - SEL_OFS[31:2] < 30'(NUM_SEL_WORDS));
    assign w_is_lock = (w_widx == LOCK_OFS[31:2]);
    assign w_is_in   = (w_widx >= IN_OFS[31:2]) && (w_in_idx < 30'(NUM_IN_WORDS));
    assign w_bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w_sync_ext = (NUM_IN_WORDS*32)'(w_sync);

    always_comb begin
        w_rdata = '0;
        if (w_is_sel) begin
            for (int unsigned i = 0; i < NUM_SEL_WORDS; i++) begin
                if (w_widx - SEL_OFS[31:2] == 30'(i)) begin
                    w_rdata = r_sel_w[i] & sel_word_mask(i, NUM_PADS, SELW);
                end
            end
        end else if (w_is_lock) begin
            w_rdata = {31'b0, r_lock};
        end else if (w_is_in) begin
            for (int unsigned i = 0; i < NUM_IN_WORDS; i++) begin
                if (w_in_idx == 30'(i)) begin
                    w_rdata = w_sync_ext[i*32 +: 32];
                end
            end
        end
    end

    // SEL writes see the lock value from before this edge, so a lock
    // taking effect never blocks the write it accompanies.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack  <= 1'b0;
            r_dat  <= '0;
            r_lock <= 1'b0;
            for (int unsigned i = 0; i < NUM_SEL_WORDS; i++) begin
                r_sel_w[i] <= '0;
            end
        end else begin
            r_ack <= w_req;
            r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
            if (w_wr && w_is_lock && wbs_sel_i[0] && wbs_dat_i[0]) begin
                r_lock <= 1'b1;
            end
            for (int unsigned i = 0; i < NUM_SEL_WORDS; i++) begin
                if (w_wr && w_is_sel && !r_lock && (w_widx - SEL_OFS[31:2] == 30'(i))) begin
                    r_sel_w[i] <= (r_sel_w[i] & ~(w_bmask & sel_word_mask(i, NUM_PADS, SELW)))
                                | (wbs_dat_i & w_bmask & sel_word_mask(i, NUM_PADS, SELW));
                end
            end
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign locked_o  = r_lock;

    // ---------------------------------------------------------------
    // Per-pad routing
    // ---------------------------------------------------------------
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        logic [SELW-1:0]      w_s;
        logic [NUM_FUNCS-1:0] w_po;
        logic [NUM_FUNCS-1:0] w_oe;

        assign w_s  = r_sel_w[p / PPW][(p % PPW) * SELW +: SELW];
        assign w_po = periph_out[p*NUM_FUNCS +: NUM_FUNCS];
        assign w_oe = periph_oe[p*NUM_FUNCS +: NUM_FUNCS];

        assign io_out[p] = w_po[w_s];
        assign io_oeb[p] = ~w_oe[w_s];

        for (genvar k = 0; k < NUM_FUNCS; k++) begin : g_func
            assign periph_in[p*NUM_FUNCS + k] = (w_s == SELW'(k)) ? w_sync[p] : 1'b0;
        end
    end

endmodule

// File: tb/tb_io_pinmux_wb.sv
// tb_io_pinmux_wb: scoreboard bench for io_pinmux_wb (37 pads, 4 functions,
// 2 sync stages). Expected read data is queued when a read is issued and
// compared when the ack arrives.
module tb_io_pinmux_wb;

    localparam int unsigned NP = 37;
    localparam int unsigned NF = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic            clk = 1'b0;
    logic            rst;
    logic            stb, cyc, we;
    logic [3:0]      sel;
    logic [31:0]     adr, dat_i;
    logic            ack;
    logic [31:0]     dat_o;
    logic [NP-1:0]   io_in, io_out, io_oeb;
    logic [NP*NF-1:0] p_out, p_oe, p_in;
    logic            locked;

    int unsigned     n_checks = 0;
    int unsigned     n_fail   = 0;
    logic [31:0]     exp_q[$];
    string           tag_q[$];

    io_pinmux_wb #(
        .NUM_PADS    (NP),
        .NUM_FUNCS   (NF),
        .SYNC_STAGES (2),
        .BASE_ADDR   (BASE)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_o),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oeb     (io_oeb),
        .periph_out (p_out),
        .periph_oe  (p_oe),
        .periph_in  (p_in),
        .locked_o   (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus access; inputs change on the falling edge. Ack must appear
    // exactly one cycle after the request and drop the following cycle.
    task automatic wb_cycle(input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        int unsigned n;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        check("ack_latency", 32'(n), 32'd1);
        if (!w) begin
            if (exp_q.size() != 0) begin
                check(tag_q.pop_front(), dat_o, exp_q.pop_front());
            end else begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 32'd0);
        check("dat_idle_zero", dat_o, 32'd0);
    endtask

    task automatic wb_write(input logic [31:0] ofs, input logic [31:0] d, input logic [3:0] s);
        wb_cycle(1'b1, BASE + ofs, d, s);
    endtask

    task automatic wb_read_abs(input string tag, input logic [31:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        wb_cycle(1'b0, a, 32'd0, 4'hF);
    endtask

    task automatic wb_read(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
        wb_read_abs(tag, BASE + ofs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; dat_i = '0;
        io_in = '0; p_out = '0; p_oe = '0;
        io_in[36:32] = 5'b10110;
        do_reset();

        // 1. reset state and function-0 routing
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", dat_o, 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        wb_read("sel0_rst", 32'h000, 32'h0);
        wb_read("lock_rst", 32'h100, 32'h0);
        p_out[12] = 1'b1; p_oe[12] = 1'b1;
        #1;
        check("pad3_f0_out", 32'(io_out[3]), 32'd1);
        check("pad3_f0_oeb", 32'(io_oeb[3]), 32'd0);

        // 2. pad3 -> function 2; pad should change coincident with ack
        p_out[12] = 1'b0;
        p_out[14] = 1'b1; p_oe[14] = 1'b0;
        #1;
        check("pad3_pre_out", 32'(io_out[3]), 32'd0);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE; dat_i = 32'h80; sel = 4'hF;
        @(negedge clk);
        check("sel_wr_ack", 32'(ack), 32'd1);
        check("pad3_f2_out", 32'(io_out[3]), 32'd1);
        check("pad3_f2_oeb", 32'(io_oeb[3]), 32'd1);
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        check("sel_wr_ack_drop", 32'(ack), 32'd0);
        wb_read("sel0_f2", 32'h000, 32'h80);

        // 3. pad5 -> function 1, input latency
        wb_write(32'h000, 32'h0000_0480, 4'hF);
        repeat (2) @(negedge clk);
        check("pin21_idle", 32'(p_in[21]), 32'd0);
        io_in[5] = 1'b1;
        @(negedge clk);
        check("pin21_lat1", 32'(p_in[21]), 32'd0);
        @(negedge clk);
        check("pin21_lat2", 32'(p_in[21]), 32'd1);
        check("pin20_unsel", 32'(p_in[20]), 32'd0);
        check("pin22_unsel", 32'(p_in[22]), 32'd0);
        wb_read("in0", 32'h200, 32'h0000_0020);
        wb_read("in1", 32'h204, 32'h0000_0016);
        wb_write(32'h200, 32'hFFFF_FFFF, 4'hF);
        wb_read("in0_ro", 32'h200, 32'h0000_0020);

        // byte-enabled SEL write
        wb_write(32'h004, 32'hA5C3_5A3C, 4'b0110);
        wb_read("sel1_bytes", 32'h004, 32'h00C3_5A00);

        // 4. lock
        wb_write(32'h100, 32'h1, 4'hF);
        check("locked_set", 32'(locked), 32'd1);
        wb_write(32'h000, 32'hFFFF_FFFF, 4'hF);
        wb_read("sel0_locked", 32'h000, 32'h0000_0480);
        wb_read("lock_rd", 32'h100, 32'h1);
        wb_write(32'h100, 32'h0, 4'hF);
        check("lock_sticky", 32'(locked), 32'd1);

        // reset with a request outstanding: dropped, no ack
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE; rst = 1'b1;
        @(negedge clk);
        check("rst_drop_ack", 32'(ack), 32'd0);
        stb = 1'b0; cyc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_unlock", 32'(locked), 32'd0);
        wb_read("sel0_after_rst", 32'h000, 32'h0);
        wb_read("lock_after_rst", 32'h100, 32'h0);

        // 5. partial last SEL word (pads 32..36 -> bits [9:0])
        wb_write(32'h008, 32'hFFFF_FFFF, 4'b0001);
        wb_read("sel2_byte0", 32'h008, 32'h0000_00FF);
        wb_write(32'h008, 32'hFFFF_FFFF, 4'hF);
        wb_read("sel2_full", 32'h008, 32'h0000_03FF);

        // 6. unmapped offsets
        wb_read("unmapped_3fc", 32'h3FC, 32'h0);
        wb_write(32'h104, 32'hFFFF_FFFF, 4'hF);
        wb_read("lock_after_104", 32'h100, 32'h0);
        wb_read("sel0_after_104", 32'h000, 32'h0);
        wb_read("sel3_absent", 32'h00C, 32'h0);
        wb_read("in2_absent", 32'h208, 32'h0);
        wb_read_abs("outside_block", 32'h2000_0000, 32'h0);
        check("locked_final", 32'(locked), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
